jalu_serial: RTL and testbench

- Bit-serial, parametrised ALU for the jcscpu datapath: one WIDTH-bit operation processed one bit per clock through a single add/compare/logic bit-slice.
- Generalises the combinational full-adder and compare bit-cells into a width-independent sequential unit with chained carry, equal and a-larger state.
- Adds a start/busy/done handshake and registered flags.
- Trades area for WIDTH-cycle latency; the same slice serves any WIDTH.

---
 rtl/jalu_serial.sv | 252 +++++++++++++++++++++++++
 tb/tb_jalu_serial.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jalu_serial.sv
// jalu_serial -- bit-serial WIDTH-bit ALU built around one add/compare/logic
// bit-slice. One operand bit is processed per clock, LSB first, so an
// operation takes WIDTH cycles from an accepted start to the done pulse.
//
// Optional build macro: JALU_SERIAL_ABORT_EN adds the 'abort' input, which
// cancels a running operation without a done pulse.
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous active-high reset
//   start     : operation request, sampled only while idle
//   op        : 000 ADD, 001 SHR, 010 SHL, 011 NOT, 100 AND, 101 OR,
//               110 XOR, 111 CMP
//   a, b      : operands, latched on an accepted start
//   carry_in  : carry / shift-in bit, latched on an accepted start
//   abort     : (JALU_SERIAL_ABORT_EN only) cancel the running operation
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse when result and flags are updated
//   result    : registered result, held until the next done
//   carry_out : registered carry / shift-out flag
//   a_larger  : registered unsigned A>B flag (CMP only)
//   equal     : registered A==B flag (CMP only)
//   zero      : registered result==0 flag

module jalu_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef JALU_SERIAL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             a_larger,
  output logic             equal,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic abort_w;
`ifdef JALU_SERIAL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Control and operand state
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] acc_q,   acc_d;   // partial result, filled from the MSB end

  // Slice chain state
  logic             c_q,     c_d;     // carry / shift-in
  logic             eq_q,    eq_d;
  logic             al_q,    al_d;
  logic             sh_q,    sh_d;    // a[0] kept for the SHR shift-out flag

  // Output registers
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             alf_q,    alf_d;
  logic             eqf_q,    eqf_d;
  logic             zero_q,   zero_d;

  // Bit-slice signals
  logic             ai, bi, a_nx;
  logic             last;
  logic             r_bit;
  logic             c_nx, eq_nx, al_nx;
  logic [WIDTH-1:0] res_full;
  logic             cout_fin;

  assign ai   = a_q[0];
  assign bi   = b_q[0];
  assign a_nx = a_q[1];
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    r_bit = 1'b0;
    c_nx  = c_q;
    eq_nx = eq_q;
    al_nx = al_q;
    case (op_q)
      OP_ADD: begin
        r_bit = ai ^ bi ^ c_q;
        c_nx  = (ai & bi) | (c_q & (ai ^ bi));
      end
      // SHR needs the next-higher operand bit; the latched carry_in fills
      // the MSB, so c_q is left untouched for the whole run.
      OP_SHR: r_bit = last ? c_q : a_nx;
      // SHL delays operand bits by one slot through the carry; the bit left
      // in the carry after the MSB is the shift-out.
      OP_SHL: begin
        r_bit = c_q;
        c_nx  = ai;
      end
      OP_NOT: r_bit = ~ai;
      OP_AND: r_bit = ai & bi;
      OP_OR:  r_bit = ai | bi;
      OP_XOR: r_bit = ai ^ bi;
      OP_CMP: begin
        r_bit = ai ^ bi;
        // Higher differing bits override lower ones, LSB-first scan.
        if (ai != bi) al_nx = ai;
        eq_nx = eq_q & ~(ai ^ bi);
      end
      default: r_bit = 1'b0;
    endcase
  end

  assign res_full = {r_bit, acc_q[WIDTH-1:1]};

  always_comb begin
    case (op_q)
      OP_ADD, OP_SHL: cout_fin = c_nx;
      OP_SHR:         cout_fin = sh_q;
      default:        cout_fin = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    c_d      = c_q;
    eq_d     = eq_q;
    al_d     = al_q;
    sh_d     = sh_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    alf_d    = alf_q;
    eqf_d    = eqf_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          c_d     = carry_in;
          eq_d    = 1'b1;
          al_d    = 1'b0;
          sh_d    = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          a_d   = {1'b0, a_q[WIDTH-1:1]};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
          acc_d = res_full;
          c_d   = c_nx;
          eq_d  = eq_nx;
          al_d  = al_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == '0) sh_d = ai;
          if (last) begin
            result_d = res_full;
            cout_d   = cout_fin;
            alf_d    = (op_q == OP_CMP) ? al_nx : 1'b0;
            eqf_d    = (op_q == OP_CMP) ? eq_nx : 1'b0;
            zero_d   = (res_full == '0);
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      eq_q     <= 1'b0;
      al_q     <= 1'b0;
      sh_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      alf_q    <= 1'b0;
      eqf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      eq_q     <= eq_d;
      al_q     <= al_d;
      sh_q     <= sh_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      alf_q    <= alf_d;
      eqf_q    <= eqf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign a_larger  = alf_q;
  assign equal     = eqf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_jalu_serial.sv
module tb_jalu_serial;

  localparam int unsigned W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         al;
    logic         eq;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         carry_in;
`ifdef JALU_SERIAL_ABORT_EN
  logic         abort;
`endif
  logic         busy, done, carry_out, a_larger, equal, zero;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;

  exp_t exp_q[$];
  int   cyc_q[$];

  jalu_serial #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
`ifdef JALU_SERIAL_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .a_larger (a_larger),
    .equal    (equal),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    case (o)
      OP_ADD: begin
        s   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.r = s[W-1:0];
        e.c = s[W];
      end
      OP_SHR: begin e.r = {ci, x[W-1:1]}; e.c = x[0];   end
      OP_SHL: begin e.r = {x[W-2:0], ci}; e.c = x[W-1]; end
      OP_NOT: e.r = ~x;
      OP_AND: e.r = x & y;
      3'b101: e.r = x | y;
      OP_XOR: e.r = x ^ y;
      default: begin
        e.r  = x ^ y;
        e.al = (x > y);
        e.eq = (x == y);
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard push on every accepted start; aborted operations are dropped.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
`ifdef JALU_SERIAL_ABORT_EN
      if (abort && busy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
`endif
      if (start && !busy) begin
        exp_q.push_back(model(op, a, b, carry_in));
        cyc_q.push_back(cyc);
      end
    end
  end

  always @(posedge reset) begin
    exp_q.delete();
    cyc_q.delete();
  end

  // Pop and compare when the DUT signals done.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      int   c0;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        c0 = cyc_q.pop_front();
        check("result",    {24'd0, result},      {24'd0, e.r});
        check("carry_out", {31'd0, carry_out},   {31'd0, e.c});
        check("a_larger",  {31'd0, a_larger},    {31'd0, e.al});
        check("equal",     {31'd0, equal},       {31'd0, e.eq});
        check("zero",      {31'd0, zero},        {31'd0, e.z});
        check("latency",   32'(cyc - c0),        32'(W));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ci);
    op = o; a = x; b = y; carry_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic ci);
    issue(o, x, y, ci);
    wait_done(W + 4);
    tick();
  endtask

`ifdef JALU_SERIAL_ABORT_EN
  task automatic check_held(input string tag, input logic [W+3:0] prev);
    check(tag, {20'd0, result, carry_out, a_larger, equal, zero}, {20'd0, prev});
  endtask
`endif

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
`ifdef JALU_SERIAL_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_result", {24'd0, result},    32'd0);
    check("rst_flags",  {28'd0, carry_out, a_larger, equal, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ADD with busy/done timing
    issue(OP_ADD, 8'd200, 8'd100, 1'b0);
    for (int i = 1; i < W; i++) begin
      tick();
      check("add_busy", {31'd0, busy}, 32'd1);
      check("add_nodone", {31'd0, done}, 32'd0);
    end
    tick();
    check("add_done", {31'd0, done}, 32'd1);
    check("add_idle", {31'd0, busy}, 32'd0);
    check("add_res",  {24'd0, result}, 32'h2C);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);

    run(OP_CMP, 8'h5A, 8'h5A, 1'b0);
    run(OP_CMP, 8'h80, 8'h7F, 1'b0);
    run(OP_CMP, 8'h7F, 8'h80, 1'b0);
    run(OP_SHL, 8'h81, 8'h00, 1'b1);
    run(OP_SHR, 8'h81, 8'h00, 1'b0);
    run(OP_ADD, 8'hFF, 8'h00, 1'b1);

    // Starts during RUN are ignored; start in the done cycle is accepted
    d0 = done_cnt;
    issue(OP_ADD, 8'd1, 8'd1, 1'b0);
    tick();
    op = OP_ADD; a = 8'd5; b = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(W + 4);
    check("hs_res", {24'd0, result}, 32'h02);
    issue(OP_XOR, 8'hF0, 8'hFF, 1'b0);
    wait_done(W + 4);
    check("hs_xor", {24'd0, result}, 32'h0F);
    tick();
    check("hs_done_count", 32'(done_cnt - d0), 32'd2);

    // Asynchronous reset mid-operation
    d0 = done_cnt;
    issue(OP_ADD, 8'hFF, 8'h01, 1'b0);
    tick(); tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy",   {31'd0, busy},   32'd0);
    check("arst_result", {24'd0, result}, 32'd0);
    check("arst_flags",  {27'd0, done, carry_out, a_larger, equal, zero}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    run(OP_AND, 8'hF0, 8'h3C, 1'b0);
    check("and_res", {24'd0, result}, 32'h30);

    // Random operations through the scoreboard
    for (int i = 0; i < 24; i++)
      run(3'($urandom_range(7)), 8'($urandom), 8'($urandom), 1'($urandom));

`ifdef JALU_SERIAL_ABORT_EN
    begin
      logic [W+3:0] prev;
      run(OP_ADD, 8'h12, 8'h34, 1'b0);
      prev = {result, carry_out, a_larger, equal, zero};
      d0 = done_cnt;
      issue(OP_NOT, 8'h00, 8'h00, 1'b0);
      tick(); tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check_held("abort_held", prev);
      issue(OP_NOT, 8'h00, 8'h00, 1'b0);
      for (int i = 1; i < W; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_last_done", {31'd0, done}, 32'd0);
      check("abort_last_busy", {31'd0, busy}, 32'd0);
      check_held("abort_last_held", prev);
      tick(); tick();
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      abort = 1'b1;
      issue(OP_NOT, 8'h00, 8'h00, 1'b0);
      abort = 1'b0;
      wait_done(W + 4);
      check("abort_idle_res", {24'd0, result}, 32'hFF);
      tick();
    end
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
